zigzag_buf: RTL and testbench
=============================

ZIGZAG_BUF -- requirements
Module: zigzag_buf

Interface
REQ-001 Parameter DW, default 12: coefficient width, matching the DCT coefficient output.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: asynchronous active-low reset.
REQ-004 Port in_valid, input, 1: a raster-order DCT coefficient is present on in_data.
REQ-005 Port in_data, input, DW: signed coefficient, raster order (row-major, 64 per 8x8 block).
REQ-006 Port in_ready, output, 1: the block can accept a coefficient this cycle.
REQ-007 Port out_valid, output, 1: out_data holds a zigzag-ordered coefficient.
REQ-008 Port out_data, output, DW: coefficient, unchanged value, zigzag order.
REQ-009 Port out_last, output, 1: high with out_valid on zigzag index 63.
REQ-010 Port out_ready, input, 1: the downstream stage accepts out_data this cycle.

Function
REQ-011 Two 64xDW banks (ping-pong); write pointer wsel, read pointer rsel, one full flag per bank.
REQ-012 Input transfer: in_valid and in_ready both high; in_data is written to bank wsel at address wcnt (0..63), and wcnt increments.
REQ-013 in_ready = not full[wsel].
REQ-014 On the transfer with wcnt=63: full[wsel] is set, wcnt wraps to 0, and wsel toggles.
REQ-015 The read FSM has two states, IDLE and READ. IDLE -> READ when full[rsel]=1. READ -> IDLE after index 63 transfers.
REQ-016 In READ, out_data is the registered bank[rsel][ZZ[rcnt]]. ZZ is the standard JPEG zigzag table: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,... ending 55,62,63.
REQ-017 Output transfer: out_valid and out_ready both high; rcnt increments.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_last hold stable.
REQ-019 On the transfer with rcnt=63: full[rsel] clears, rsel toggles, and rcnt wraps to 0.
REQ-020 out_valid rises exactly 2 cycles after the edge that accepted the 64th input of a bank, when that bank is next to read.
REQ-021 With out_ready held high, one coefficient is output per cycle with no bubbles, including across back-to-back blocks.
REQ-022 Simultaneous events: in the same cycle, the final read of a bank may clear its flag while the final write of the other bank sets that bank's flag. Both updates take effect.
REQ-023 A bank freed in cycle N makes in_ready high in cycle N+1.
REQ-024 Throughput is sustained at 1 coefficient per cycle when out_ready stays high.

Reset
REQ-025 While rst=0: out_valid=0, out_last=0, out_data=0, in_ready=1, wcnt=rcnt=0, wsel=rsel=0, both full flags=0, FSM=IDLE.
REQ-026 Reset asserted mid-block discards all partial and full banks. Bank contents need not be cleared.
REQ-027 After rst returns high, the first accepted input is treated as raster index 0 of a new block.

Configuration
REQ-028 Macro ZIGZAG_BUF_ERR_EN.
- Defined: adds output port err (1 bit). err is a sticky flag, set the cycle after in_valid=1 while in_ready=0. err clears only on reset, and its reset value is 0.
- Undefined: the err port is absent, and in_valid while in_ready=0 is silently ignored (no write).

Verification
REQ-029 Basic ordering: one block with in_data=k for k=0..63, out_ready=1.
- Outputs in order 0,1,8,16,9,2,3,10,...,62,63.
- out_last is high only on 63.
- out_valid first rises 2 cycles after the input with k=63 is accepted.
REQ-030 Backpressure: out_ready=0 after the 3rd output beat, held 5 cycles.
- out_data holds 16 and out_valid stays 1 throughout.
- The sequence resumes with 9, no loss or duplicate.
REQ-031 Back-to-back blocks: 3 blocks (values k, 100+k, 200+k), in_valid continuous, out_ready=1.
- 192 consecutive output beats with no gaps.
- in_ready never drops.
REQ-032 Full stall: out_ready=0 while 2 blocks are written.
- in_ready=0 after the 128th input.
- After out_ready=1 and 64 output beats, in_ready returns to 1 the following cycle.
REQ-033 Reset mid-block: assert rst=0 after 30 inputs.
- out_valid=0 and in_ready=1 during reset.
- A full new block then outputs its own data in correct zigzag order.
REQ-034 With ZIGZAG_BUF_ERR_EN defined: repeat REQ-032, holding in_valid=1 during the stall.
- err=1 from the cycle after the first rejected input.
- err stays 1 until rst=0.

Source files
------------

// File: rtl/zigzag_buf.sv
// zigzag_buf: ping-pong 8x8 coefficient buffer, raster order in, JPEG zigzag order out.
// Define ZIGZAG_BUF_ERR_EN to add the sticky `err` output for writes attempted while full.
module zigzag_buf #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
`ifdef ZIGZAG_BUF_ERR_EN
  ,
  output logic          err
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_t;

  // Zigzag index -> raster address within an 8x8 block.
  function automatic logic [5:0] zz_addr(input logic [5:0] idx);
    logic [5:0] a;
    case (idx)
      6'd0:  a = 6'd0;  6'd1:  a = 6'd1;  6'd2:  a = 6'd8;  6'd3:  a = 6'd16;
      6'd4:  a = 6'd9;  6'd5:  a = 6'd2;  6'd6:  a = 6'd3;  6'd7:  a = 6'd10;
      6'd8:  a = 6'd17; 6'd9:  a = 6'd24; 6'd10: a = 6'd32; 6'd11: a = 6'd25;
      6'd12: a = 6'd18; 6'd13: a = 6'd11; 6'd14: a = 6'd4;  6'd15: a = 6'd5;
      6'd16: a = 6'd12; 6'd17: a = 6'd19; 6'd18: a = 6'd26; 6'd19: a = 6'd33;
      6'd20: a = 6'd40; 6'd21: a = 6'd48; 6'd22: a = 6'd41; 6'd23: a = 6'd34;
      6'd24: a = 6'd27; 6'd25: a = 6'd20; 6'd26: a = 6'd13; 6'd27: a = 6'd6;
      6'd28: a = 6'd7;  6'd29: a = 6'd14; 6'd30: a = 6'd21; 6'd31: a = 6'd28;
      6'd32: a = 6'd35; 6'd33: a = 6'd42; 6'd34: a = 6'd49; 6'd35: a = 6'd56;
      6'd36: a = 6'd57; 6'd37: a = 6'd50; 6'd38: a = 6'd43; 6'd39: a = 6'd36;
      6'd40: a = 6'd29; 6'd41: a = 6'd22; 6'd42: a = 6'd15; 6'd43: a = 6'd23;
      6'd44: a = 6'd30; 6'd45: a = 6'd37; 6'd46: a = 6'd44; 6'd47: a = 6'd51;
      6'd48: a = 6'd58; 6'd49: a = 6'd59; 6'd50: a = 6'd52; 6'd51: a = 6'd45;
      6'd52: a = 6'd38; 6'd53: a = 6'd31; 6'd54: a = 6'd39; 6'd55: a = 6'd46;
      6'd56: a = 6'd53; 6'd57: a = 6'd60; 6'd58: a = 6'd61; 6'd59: a = 6'd54;
      6'd60: a = 6'd47; 6'd61: a = 6'd55; 6'd62: a = 6'd62; 6'd63: a = 6'd63;
      default: a = 6'd0;
    endcase
    return a;
  endfunction

  logic [DW-1:0] mem_r [0:1][0:63];
  logic [5:0]    wcnt_r;
  logic [5:0]    rcnt_r;
  logic          wsel_r;
  logic          rsel_r;
  logic [1:0]    full_r;
  logic          in_ready_r;
  rd_state_t     state_r;
  logic          out_valid_r;
  logic          out_last_r;
  logic [DW-1:0] out_data_r;

  logic          wr_fire_s;
  logic          wr_last_s;
  logic          rd_fire_s;
  logic          rd_last_s;
  logic          wsel_nxt_s;
  logic          rsel_other_s;
  logic [1:0]    full_set_s;
  logic [1:0]    full_clr_s;
  logic [1:0]    full_nxt_s;
  logic          next_full_s;
  logic          rd_bank_s;
  logic [5:0]    rd_idx_s;
  logic [5:0]    rd_addr_s;
  logic [DW-1:0] rd_word_s;

  assign wr_fire_s    = in_valid & in_ready_r;
  assign wr_last_s    = wr_fire_s & (wcnt_r == 6'd63);
  assign rd_fire_s    = (state_r == ST_READ) & out_valid_r & out_ready;
  assign rd_last_s    = rd_fire_s & (rcnt_r == 6'd63);
  assign wsel_nxt_s   = wsel_r ^ wr_last_s;
  assign rsel_other_s = ~rsel_r;

  // A final write and a final read always target different banks, so set and clear never collide.
  assign full_set_s = {wr_last_s & wsel_r, wr_last_s & ~wsel_r};
  assign full_clr_s = {rd_last_s & rsel_r, rd_last_s & ~rsel_r};
  assign full_nxt_s = (full_r | full_set_s) & ~full_clr_s;

  // The other bank may complete on the very edge this bank drains; chaining on it avoids a bubble.
  assign next_full_s = full_r[rsel_other_s] | (wr_last_s & (wsel_r == rsel_other_s));

  // Select which bank/zigzag index feeds the output register on the next load.
  always_comb begin
    rd_bank_s = rsel_r;
    rd_idx_s  = rcnt_r;
    if (!out_valid_r) begin
      rd_bank_s = rsel_r;
      rd_idx_s  = rcnt_r;
    end else if (rcnt_r == 6'd63) begin
      rd_bank_s = rsel_other_s;
      rd_idx_s  = 6'd0;
    end else begin
      rd_bank_s = rsel_r;
      rd_idx_s  = rcnt_r + 6'd1;
    end
  end

  assign rd_addr_s = zz_addr(rd_idx_s);
  assign rd_word_s = mem_r[rd_bank_s][rd_addr_s];

  // Coefficient storage; contents are deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wsel_r][wcnt_r] <= in_data;
    end
  end

  // Write pointer, bank-full flags and registered in_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_r     <= 6'd0;
      wsel_r     <= 1'b0;
      full_r     <= 2'b00;
      in_ready_r <= 1'b1;
    end else begin
      if (wr_fire_s) begin
        wcnt_r <= wcnt_r + 6'd1;
      end
      wsel_r     <= wsel_nxt_s;
      full_r     <= full_nxt_s;
      in_ready_r <= ~full_nxt_s[wsel_nxt_s];
    end
  end

  // Read FSM with registered output beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      rcnt_r      <= 6'd0;
      rsel_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          rcnt_r      <= 6'd0;
          if (full_r[rsel_r]) begin
            state_r <= ST_READ;
          end
        end
        ST_READ: begin
          if (!out_valid_r) begin
            out_data_r  <= rd_word_s;
            out_valid_r <= 1'b1;
            out_last_r  <= (rcnt_r == 6'd63);
          end else if (out_ready) begin
            if (rcnt_r == 6'd63) begin
              rcnt_r <= 6'd0;
              rsel_r <= rsel_other_s;
              if (next_full_s) begin
                out_data_r  <= rd_word_s;
                out_valid_r <= 1'b1;
                out_last_r  <= 1'b0;
              end else begin
                state_r     <= ST_IDLE;
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
              end
            end else begin
              rcnt_r     <= rcnt_r + 6'd1;
              out_data_r <= rd_word_s;
              out_last_r <= (rcnt_r == 6'd62);
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ZIGZAG_BUF_ERR_EN
  logic err_r;

  // Sticky flag: a write was offered while the target bank was still full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (in_valid & ~in_ready_r);
    end
  end

  assign err = err_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_zigzag_buf.sv
// Bench for zigzag_buf: queue-based block model plus directed scenarios (ordering, stall, back-to-back, reset).
module tb_zigzag_buf;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
`ifdef ZIGZAG_BUF_ERR_EN
  logic          err;
`endif

  zigzag_buf #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
`ifdef ZIGZAG_BUF_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model state
  int            zz [64];
  logic [DW-1:0] blk[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_log[$];
  int            xfer_cyc_q[$];
  int            full_cnt = 0;
  int            rd_idx = 0;
  int            ready_at = 0;
  int            cyc = 0;
  int            done_cyc = 0;
  int            rise_cyc = 0;
  int            last_seen = 0;
  bit            prev_hold = 1'b0;
  bit            prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  bit            ev;
  bit            was_empty;

  // Monitor: compare against the block model mid-cycle, then apply the transfers of the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      blk.delete();
      exp_q.delete();
      full_cnt  = 0;
      rd_idx    = 0;
      ready_at  = 0;
      prev_hold = 1'b0;
      prev_valid = 1'b0;
    end else begin
      ev = (exp_q.size() > 0) && (cyc >= ready_at);
      chk("in_ready", in_ready, (full_cnt < 2) ? 32'd1 : 32'd0);
      chk("out_valid", out_valid, ev ? 32'd1 : 32'd0);
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0]);
        chk("out_last", out_last, (rd_idx == 63) ? 32'd1 : 32'd0);
      end
      if (prev_hold) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
      prev_hold  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (in_valid && in_ready) begin
        blk.push_back(in_data);
        if (blk.size() == 64) begin
          was_empty = (exp_q.size() == 0);
          for (int i = 0; i < 64; i++) exp_q.push_back(blk[zz[i]]);
          blk.delete();
          full_cnt++;
          done_cyc = cyc;
          if (was_empty) ready_at = cyc + 3;
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        out_log.push_back(out_data);
        xfer_cyc_q.push_back(cyc);
        if (out_last) last_seen++;
        void'(exp_q.pop_front());
        rd_idx++;
        if (rd_idx == 64) begin
          rd_idx = 0;
          full_cnt--;
          if (exp_q.size() > 0) ready_at = cyc + 1;
        end
      end
    end
    cyc++;
  end

  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept data=%0d", d);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_block(input int base, input int n);
    for (int k = 0; k < n; k++) send(DW'(base + k));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (out_log.size() < target && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat_count", out_log.size(), target);
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb;
    int ls;
    int n;
    // Zigzag order derived from anti-diagonal traversal.
    n = 0;
    for (int s = 0; s < 15; s++) begin
      for (int j = 7; j >= 0; j--) begin
        if (j <= s && s - j < 8) begin
          if (s % 2 == 0) zz[n] = j * 8 + (s - j);
          else            zz[n] = (s - j) * 8 + j;
          n++;
        end
      end
    end
    chk("zz_model_count", n, 64);
    chk("zz_model_2", zz[2], 8);
    chk("zz_model_10", zz[10], 32);
    chk("zz_model_63", zz[63], 63);

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef ZIGZAG_BUF_ERR_EN
    chk("rst_err", err, 0);
`endif
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Basic ordering
    lb = out_log.size(); ls = last_seen;
    send_block(0, 64);
    in_valid = 1'b0;
    wait_drain();
    chk("t1_beats", out_log.size() - lb, 64);
    chk("t1_b0", out_log[lb + 0], 0);
    chk("t1_b1", out_log[lb + 1], 1);
    chk("t1_b2", out_log[lb + 2], 8);
    chk("t1_b3", out_log[lb + 3], 16);
    chk("t1_b4", out_log[lb + 4], 9);
    chk("t1_b62", out_log[lb + 62], 62);
    chk("t1_b63", out_log[lb + 63], 63);
    chk("t1_last_count", last_seen - ls, 1);
    chk("t1_latency", rise_cyc - (done_cyc + 1), 2);

    // Backpressure after the 3rd beat
    lb = out_log.size();
    fork
      begin
        send_block(0, 64);
        in_valid = 1'b0;
      end
      begin : stall_ctl
        int m;
        m = 0;
        while (out_log.size() < lb + 3 && m < 500) begin
          @(posedge clk); #1;
          m++;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          chk("t2_hold_valid", out_valid, 1);
          chk("t2_hold_data", out_data, 16);
          if (i < 4) begin
            @(posedge clk); #1;
          end
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("t2_beats", out_log.size() - lb, 64);
    chk("t2_b3", out_log[lb + 3], 16);
    chk("t2_b4", out_log[lb + 4], 9);
    chk("t2_b5", out_log[lb + 5], 2);

    // Full stall: two blocks written with no reads, in_valid kept high while rejected
    lb = out_log.size();
    out_ready = 1'b0;
    send_block(1000, 64);
    send_block(1100, 64);
    in_data = DW'(2000);
    chk("t4_in_ready_low", in_ready, 0);
`ifdef ZIGZAG_BUF_ERR_EN
    chk("t4_err_before", err, 0);
`endif
    @(posedge clk); #1;
`ifdef ZIGZAG_BUF_ERR_EN
    chk("t4_err_set", err, 1);
`endif
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t4_stall_valid", out_valid, 1);
    chk("t4_stall_data", out_data, 1000);
    chk("t4_still_full", in_ready, 0);
    out_ready = 1'b1;
    wait_beats(lb + 64);
    chk("t4_in_ready_back", in_ready, 1);
    in_valid = 1'b0;
    wait_drain();
    chk("t4_beats", out_log.size() - lb, 128);
    chk("t4_blkB_b0", out_log[lb + 64], 1100);
    chk("t4_blkB_b2", out_log[lb + 66], 1108);
`ifdef ZIGZAG_BUF_ERR_EN
    chk("t4_err_sticky", err, 1);
`endif

    // Back-to-back blocks
    lb = out_log.size();
    send_block(0, 64);
    send_block(100, 64);
    send_block(200, 64);
    in_valid = 1'b0;
    wait_drain();
    chk("t3_beats", out_log.size() - lb, 192);
    chk("t3_span", xfer_cyc_q[lb + 191] - xfer_cyc_q[lb], 191);
    chk("t3_b63", out_log[lb + 63], 63);
    chk("t3_b64", out_log[lb + 64], 100);
    chk("t3_b129", out_log[lb + 129], 201);
    chk("t3_b191", out_log[lb + 191], 263);

    // Reset mid-block
`ifdef ZIGZAG_BUF_ERR_EN
    chk("t5_err_pre_rst", err, 1);
`endif
    send_block(500, 30);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_in_ready", in_ready, 1);
`ifdef ZIGZAG_BUF_ERR_EN
    chk("t5_rst_err", err, 0);
`endif
    @(posedge clk); #1;
    chk("t5_rst_out_valid2", out_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    lb = out_log.size();
    send_block(600, 64);
    in_valid = 1'b0;
    wait_drain();
    chk("t5_beats", out_log.size() - lb, 64);
    chk("t5_b0", out_log[lb + 0], 600);
    chk("t5_b2", out_log[lb + 2], 608);
    chk("t5_b5", out_log[lb + 5], 602);
    chk("t5_b63", out_log[lb + 63], 663);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
